// File: rtl/rotator_pkg.sv
// Shared types and defaults for the rotator arbiter: data/amount widths,
// result-register state encoding and rotate-direction constants.
package rotator_pkg;

  localparam int ROT_W  = 8;
  localparam int ROT_AW = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/rotator_arbiter_if.sv
// Request/response bundle between the client blocks (master) and the
// shared rotator arbiter (slave).
interface rotator_arbiter_if
  import rotator_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ROT_W,
  parameter int AW   = ROT_AW,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*W-1:0]  req_data;
  logic [NREQ*AW-1:0] req_amt;
  logic [NREQ-1:0]    req_lr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_data;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_data, req_amt, req_lr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_lr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/barrel_rotator.sv
// Purely combinational W-bit rotator; lr selects left (ROT_LEFT) or
// right (ROT_RIGHT), amount is taken modulo W.
module barrel_rotator
  import rotator_pkg::*;
#(
  parameter int W  = ROT_W,
  parameter int AW = ROT_AW
) (
  input  logic [W-1:0]  a,
  input  logic [AW-1:0] amt,
  input  logic          lr,
  output logic [W-1:0]  y
);

  // Output bit i picks input bit i+amt (right) or i-amt (left), wrapping at W.
  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) begin
      if (lr == ROT_RIGHT) y[i] = a[AW'((i + int'(amt)) % W)];
      else                 y[i] = a[AW'((i + W - int'(amt)) % W)];
    end
  end

endmodule

// File: rtl/rotator_arbiter.sv
// Round-robin arbiter sharing one barrel rotator among NREQ requesters,
// with a one-entry registered result. Define ROT_ARB_STATS_EN to add grant_count.
module rotator_arbiter
  import rotator_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ROT_W,
  parameter int AW   = ROT_AW,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  rotator_arbiter_if.slave  bus
`ifdef ROT_ARB_STATS_EN
  ,
  output logic [15:0]       grant_count
`endif
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] win_idx;
  logic           found;
  logic           can_accept;
  logic [W-1:0]   rot_y;
  logic [W-1:0]   op_data [NREQ];
  logic [AW-1:0]  op_amt  [NREQ];
`ifdef ROT_ARB_STATS_EN
  logic [15:0]    grant_count_q, grant_count_d;
`endif

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    return IDW'((int'(base) + k) % NREQ);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_data[i] = bus.req_data[i*W +: W];
      op_amt[i]  = bus.req_amt[i*AW +: AW];
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        found   = 1'b1;
        win_idx = wrap_add(rr_ptr_q, k);
      end
    end
  end

  barrel_rotator #(.W(W), .AW(AW)) u_rot (
    .a   (op_data[win_idx]),
    .amt (op_amt[win_idx]),
    .lr  (bus.req_lr[win_idx]),
    .y   (rot_y)
  );

  // NOTE: combinational blocks use blocking '=' and default every output
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    can_accept    = rst_n && ((state_q == EMPTY) || bus.rsp_ready);
    bus.req_ready = '0;
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
`ifdef ROT_ARB_STATS_EN
    grant_count_d = grant_count_q;
`endif
    if (can_accept && found) begin
      bus.req_ready[win_idx] = 1'b1;
      rsp_data_d             = rot_y;
      rsp_id_d               = win_idx;
      rr_ptr_d               = wrap_add(win_idx, 1);
      state_d                = FULL;
`ifdef ROT_ARB_STATS_EN
      grant_count_d          = grant_count_q + 16'd1;
`endif
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      rr_ptr_q      <= '0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
`ifdef ROT_ARB_STATS_EN
      grant_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
`ifdef ROT_ARB_STATS_EN
      grant_count_q <= grant_count_d;
`endif
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
`ifdef ROT_ARB_STATS_EN
  assign grant_count   = grant_count_q;
`endif

endmodule

// File: tb/tb_rotator_arbiter.sv
// Scoreboard bench for rotator_arbiter: a high-level model predicts grants and
// results, a separate monitor pops expected responses when the DUT hands them out.
module tb_rotator_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int AW   = 3;
  localparam int IDW  = 2;

  typedef struct {
    logic [W-1:0]   data;
    logic [IDW-1:0] id;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotator_arbiter_if #(.NREQ(NREQ), .W(W), .AW(AW), .IDW(IDW)) bus ();
`ifdef ROT_ARB_STATS_EN
  logic [15:0] grant_count;
`endif

  rotator_arbiter #(.NREQ(NREQ), .W(W), .AW(AW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ROT_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  rsp_t          sb[$];
  rsp_t          mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  int            rr_ptr_m = 0;
  int            acc_cnt = 0;
  int            last_win;
  logic [NREQ-1:0] last_rdy;
  bit            started = 0;
  logic [W-1:0]  p_data  [NREQ];
  logic [AW-1:0] p_amt   [NREQ];
  logic          p_lr    [NREQ];
  logic          p_valid [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotate right by k is rotate left by W-k; both reduce to one left rotate.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] x, input int k, input logic right);
    int v;
    int sh;
    int r;
    v  = int'(x);
    sh = right ? (W - k) % W : k % W;
    r  = ((v << sh) | (v >> (W - sh))) & ((1 << W) - 1);
    return W'(r);
  endfunction

  task automatic apply(input logic ready);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = p_valid[i];
      bus.req_data[i*W +: W]    = p_data[i];
      bus.req_amt[i*AW +: AW]   = p_amt[i];
      bus.req_lr[i]             = p_lr[i];
    end
    bus.rsp_ready = ready;
  endtask

  // Called at a negedge after inputs are applied; the monitor has already
  // popped any response consumed this cycle, so an empty scoreboard means
  // the DUT can accept on the coming edge.
  task automatic step(input bit use_exp, input logic [W-1:0] exp_data);
    int win;
    logic [NREQ-1:0] exp_rdy;
    rsp_t e;
    #2;
    win = -1;
    exp_rdy = '0;
    if (rst_n && sb.size() == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && p_valid[(rr_ptr_m + k) % NREQ]) win = (rr_ptr_m + k) % NREQ;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    last_rdy = bus.req_ready;
    last_win = win;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (win >= 0) begin
      e.data = use_exp ? exp_data : ref_rot(p_data[win], int'(p_amt[win]), p_lr[win]);
      e.id   = IDW'(win);
      sb.push_back(e);
      rr_ptr_m = (win + 1) % NREQ;
      acc_cnt++;
      p_valid[win] = 1'b0;
    end
    if (!rst_n) begin
      sb.delete();
      rr_ptr_m = 0;
      acc_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
  endtask

  task automatic all_valid();
    for (int i = 0; i < NREQ; i++) begin
      p_valid[i] = 1'b1;
      p_data[i]  = W'($urandom);
      p_amt[i]   = AW'($urandom);
      p_lr[i]    = 1'($urandom);
    end
  endtask

  task automatic dir_req(input int amt, input logic lr, input logic [W-1:0] exp);
    clear_reqs();
    p_valid[0] = 1'b1;
    p_data[0]  = 8'h93;
    p_amt[0]   = AW'(amt);
    p_lr[0]    = lr;
    apply(1'b1);
    step(1'b1, exp);
    check("dir_grant", 32'(last_rdy), 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(1'b1);
    step(1'b0, '0);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the held result whenever the consumer takes it.
  always @(negedge clk) begin
    #1;
    if (started && rst_n) begin
      check("rsp_valid", 32'(bus.rsp_valid), 32'(sb.size() != 0));
      if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
        check("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
      end
    end
  end

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};

    // Reset with every requester asserting: no grant, cleared result.
    all_valid();
    apply(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_reqs();
    apply(1'b1);
    started = 1'b1;

    // Direction / amount vectors on 0x93.
    dir_req(1, 1'b0, 8'h27);
    dir_req(3, 1'b0, 8'h9C);
    dir_req(5, 1'b0, 8'h72);
    dir_req(2, 1'b1, 8'hE4);
    dir_req(0, 1'b1, 8'h93);
    clear_reqs();
    apply(1'b1);
    step(1'b0, '0);

    // Round-robin fairness from a fresh pointer.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      all_valid();
      apply(1'b1);
      step(1'b0, '0);
      check("rr_grant", 32'(last_rdy), 32'(1 << seq[c]));
    end

    // Backpressure for three cycles, then release.
    for (int c = 0; c < 3; c++) begin
      all_valid();
      apply(1'b0);
      step(1'b0, '0);
      check("bp_req_ready", 32'(last_rdy), 32'h0);
    end
    apply(1'b1);
    step(1'b0, '0);
    check("bp_release_accept", 32'(last_rdy != '0), 32'h1);

    // Drive to FULL with rr_ptr=2, then reset mid-operation.
    do_reset();
    clear_reqs();
    p_valid[0] = 1'b1; p_valid[1] = 1'b1;
    apply(1'b1);
    step(1'b0, '0);
    p_valid[1] = 1'b1;
    apply(1'b1);
    step(1'b0, '0);
    all_valid();
    rst_n = 1'b0;
    apply(1'b0);
    step(1'b0, '0);
    rst_n = 1'b1;
    all_valid();
    apply(1'b1);
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("mid_rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    step(1'b0, '0);
    check("mid_rst_grant", 32'(last_rdy), 32'h1);

    // Randomized traffic; pending requests hold their operands until granted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          p_valid[i] = 1'b1;
          p_data[i]  = W'($urandom);
          p_amt[i]   = AW'($urandom);
          p_lr[i]    = 1'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 99) != 0);
      apply($urandom_range(0, 3) != 0);
      step(1'b0, '0);
    end
    rst_n = 1'b1;

`ifdef ROT_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_reqs();
      p_valid[0] = 1'b1;
      p_data[0] = W'($urandom);
      apply(1'b1);
      step(1'b0, '0);
    end
    check("grant_count_5", 32'(grant_count), 32'd5);
    for (int c = 0; c < 65531; c++) begin
      p_valid[0] = 1'b1;
      apply(1'b1);
      step(1'b0, '0);
    end
    check("grant_count_wrap", 32'(grant_count), 32'h0);
    check("grant_count_model", 32'(grant_count), 32'(acc_cnt & 16'hFFFF));
`endif

    clear_reqs();
    apply(1'b1);
    step(1'b0, '0);
    step(1'b0, '0);
    check("drain_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotator_arbiter.md
# rotator_arbiter

- Shares one 8-bit left/right barrel rotator among `NREQ` requesters.
- Each requester presents data, amount and direction under a valid/ready handshake.
- A round-robin scheduler grants one request per cycle; the rotated result is registered and returned with the requester ID under a second valid/ready handshake.
- Sits between the client blocks and the rotate datapath, so the datapath is never duplicated.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 8: data width.
- `AW`, 3: rotate-amount width, log2(`W`).
- `IDW`, 2: requester-ID width, log2(`NREQ`).
- `clk` in 1: the only clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NREQ`: request pending, one bit per requester.
- `req_ready` out `NREQ`: one-hot grant; the request is accepted this cycle.
- `req_data` in `NREQ*W`: operand; requester i uses slice [i*W +: W].
- `req_amt` in `NREQ*AW`: rotate amount, slice [i*AW +: AW].
- `req_lr` in `NREQ`: direction; 0 = rotate left, 1 = rotate right.
- `rsp_valid` out 1: result register holds a valid result.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out `W`: rotated result.
- `rsp_id` out `IDW`: index of the granted requester.
- `grant_count` out 16: present only with `ROT_ARB_STATS_EN`.

## Operation
- State machine with two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `can_accept` = EMPTY, or (FULL and `rsp_ready`).
- Arbitration:
  - Search starts at `rr_ptr` and wraps modulo `NREQ`.
  - The first i with `req_valid[i]`=1 wins.
  - `req_ready[i]`=1 for the winner only when `can_accept`; all other bits are 0.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, state and `rsp_ready`.
- On accept:
  - Result register loads rotate(`req_data[i]`, `req_amt[i]`, `req_lr[i]`).
  - `rsp_id` loads i.
  - `rr_ptr` loads (i+1) mod `NREQ`.
  - Next state is FULL.
- FULL and `rsp_ready` with no request pending: next state EMPTY; `rr_ptr` is unchanged.
- FULL and not `rsp_ready`:
  - Hold `rsp_data` and `rsp_id` stable.
  - `req_ready` is all zeros.
- Simultaneous consume and accept in FULL: the new result replaces the old one in the same edge, and the state stays FULL.
- Rotate arithmetic is modulo `W`:
  - Amount 0 passes the operand through unchanged.
  - Left by k equals right by (`W`−k).
- Requesters must hold `req_data`, `req_amt` and `req_lr` stable while `req_valid`=1 and not granted.
- `req_valid` may drop without a grant; no state depends on it.

## Timing
- Latency is 1 cycle: a request accepted at edge n appears with `rsp_valid`=1 after edge n.
- Throughput is 1 result per cycle while `rsp_ready`=1.
- Reset (`rst_n`=0 at a rising edge) sets:
  - state EMPTY, `rsp_valid`=0;
  - `rsp_data`=0, `rsp_id`=0;
  - `rr_ptr`=0;
  - `grant_count`=0.
- `req_ready` is 0 while `rst_n`=0.
- Reset mid-operation discards any held result with no response; a requester granted in that same cycle is not served.

## Configuration
- `ROT_ARB_STATS_EN` defined:
  - Adds the `grant_count` output, incremented by 1 on every accepted request.
  - Wraps from 0xFFFF to 0x0000.
- `ROT_ARB_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `rotator_pkg` holds:
  - the `W`/`AW` defaults;
  - the state enum EMPTY/FULL;
  - the direction constants `ROT_LEFT`=0 and `ROT_RIGHT`=1.
- Sub-module `barrel_rotator`: purely combinational, ports a, amt, lr, y.
- `rotator_arbiter` holds the arbiter, `rr_ptr`, the result register and the optional counter.

## Test plan
- Single request, left rotate:
  - Stimulus: requester 0 sends a=0x93, amt=1, lr=0, `rsp_ready`=1.
  - Response: `req_ready`=0001 that cycle; next cycle `rsp_data`=0x27, `rsp_id`=0.
- Direction and amount coverage on 0x93:
  - left 3 → 0x9C; left 5 → 0x72.
  - right 2 → 0xE4; right 0 → 0x93.
- Round-robin fairness:
  - Stimulus: all 4 `req_valid`=1 continuously, `rsp_ready`=1.
  - Response: grants 0,1,2,3,0 on consecutive cycles; `rsp_id` follows one cycle later.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 3 cycles while results and requests are pending.
  - Response: `rsp_data`/`rsp_id` stable, `req_ready`=0000.
  - On release: the held result is consumed and the next request is accepted in the same edge.
- Reset mid-operation:
  - Stimulus: `rst_n`=0 for one edge while FULL with `rr_ptr`=2.
  - Response: `rsp_valid`=0, `rsp_data`=0, and the next grant goes to requester 0.
- With `ROT_ARB_STATS_EN`:
  - 5 accepted requests → `grant_count`=5.
  - Counter preset to 0xFFFF, one more accept → 0x0000.
